// File: rtl/memory_game_multi.sv
// Memory-game controller: loads N LED pairs from a generator, flashes them,
// then checks the player's switch entries; optional strict mode with lives.
module memory_game_multi #(
   parameter int N_LEDS       = 16,
   parameter int IDX_W        = 4,
   parameter int MAX_PAIRS    = 8,
   parameter int START_PAIRS  = 3,
   parameter int FLASH_CYCLES = 50000000,
   parameter int GAP_CYCLES   = 12500000,
   parameter int SCORE_W      = 8,
   parameter int LIVES        = 3,
   parameter int STRICT       = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 bIn,
   input  logic [N_LEDS-1:0]    switchIn,
   input  logic                 gameTimeout,
   output logic                 pairReq,
   input  logic                 pairValid,
   input  logic [IDX_W-1:0]     pairA,
   input  logic [IDX_W-1:0]     pairB,
   output logic [N_LEDS-1:0]    redLight,
   output logic [MAX_PAIRS-1:0] greenLight,
   output logic [SCORE_W-1:0]   score,
   output logic [3:0]           level,
   output logic [3:0]           livesLeft,
   output logic                 timerEnable,
   output logic                 endGame,
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, LOAD, FLASH, GAP, ENTER, ROUNDWIN, GAMEEND} state_t;

   localparam int CNT_MAX = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int KW      = (MAX_PAIRS > 1) ? $clog2(MAX_PAIRS) : 1;
   localparam logic [CNT_W-1:0]     FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
   localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [N_LEDS-1:0]    LED_ONE    = N_LEDS'(1);
   localparam logic [MAX_PAIRS-1:0] G_ONE      = MAX_PAIRS'(1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         ld, k;
   logic [IDX_W-1:0]   pa [0:(1<<KW)-1];
   logic [IDX_W-1:0]   pb [0:(1<<KW)-1];
   logic [N_LEDS-1:0]  cur_mask;
   logic               pair_ok, hit, last_k;
   logic [SCORE_W:0]   score_sum;

   assign cur_mask  = (LED_ONE << pa[k[KW-1:0]]) | (LED_ONE << pb[k[KW-1:0]]);
   assign pair_ok   = (pairA != pairB) && (32'(pairA) < N_LEDS) && (32'(pairB) < N_LEDS);
   assign hit       = (switchIn == cur_mask);
   assign last_k    = (k == level - 4'd1);
   assign score_sum = {1'b0, score} + (SCORE_W+1)'(level);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (gameTimeout && state != IDLE) begin
         state_n = GAMEEND;
      end else if (enable) begin
         case (state)
            IDLE:     if (bIn) state_n = LOAD;
            LOAD:     if (ld == level) state_n = FLASH;
            FLASH:    if (cnt == FLASH_LAST) state_n = last_k ? ENTER : GAP;
            GAP:      if (cnt == GAP_LAST) state_n = FLASH;
            ENTER: begin
               if (bIn) begin
                  if (hit) begin
                     if (last_k) state_n = ROUNDWIN;
                  end else if (STRICT != 0 && livesLeft <= 4'd1) begin
                     state_n = GAMEEND;
                  end
               end
            end
            ROUNDWIN: state_n = LOAD;
            GAMEEND:  state_n = IDLE;
            default:  state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      redLight = (state == FLASH) ? cur_mask : '0;
      pairReq  = (state == LOAD) && (ld < level);
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         greenLight  <= '0;
         score       <= '0;
         level       <= 4'(START_PAIRS);
         livesLeft   <= 4'(LIVES);
         timerEnable <= 1'b0;
         endGame     <= 1'b0;
         cnt         <= '0;
         ld          <= '0;
         k           <= '0;
      end else if (gameTimeout && state != IDLE) begin
         timerEnable <= 1'b0;
         endGame     <= 1'b1;
         cnt         <= '0;
      end else if (enable) begin
         // duration counter restarts on every state change
         if (state_n != state)                  cnt <= '0;
         else if (state == FLASH || state == GAP) cnt <= cnt + 1'b1;
         case (state)
            IDLE: begin
               if (bIn) begin
                  endGame    <= 1'b0;
                  score      <= '0;
                  level      <= 4'(START_PAIRS);
                  livesLeft  <= 4'(LIVES);
                  greenLight <= '0;
                  ld         <= '0;
               end
            end
            LOAD: begin
               if (pairReq && pairValid && pair_ok) begin
                  pa[ld[KW-1:0]] <= pairA;
                  pb[ld[KW-1:0]] <= pairB;
                  ld             <= ld + 4'd1;
               end
               if (state_n == FLASH) k <= '0;
            end
            FLASH: begin
               if (state_n == ENTER) begin
                  k           <= '0;
                  timerEnable <= 1'b1;
               end
            end
            GAP: if (state_n == FLASH) k <= k + 4'd1;
            ENTER: begin
               if (bIn) begin
                  if (hit) begin
                     greenLight <= greenLight | (G_ONE << k);
                     k          <= k + 4'd1;
                  end else if (STRICT != 0) begin
                     livesLeft <= livesLeft - 4'd1;
                     if (livesLeft <= 4'd1) begin
                        timerEnable <= 1'b0;
                        endGame     <= 1'b1;
                     end
                  end
               end
            end
            ROUNDWIN: begin
               score      <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               if (level < 4'(MAX_PAIRS)) level <= level + 4'd1;
               greenLight <= '0;
               ld         <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_game_multi.sv
// Directed bench: dut0 relaxed mode with 5-bit indices, dut1 strict mode with two lives.
module tb_memory_game_multi;

   logic        clk = 1'b0;
   logic        rst, enable, bIn, gameTimeout, pairValid;
   logic [15:0] switchIn;
   logic [4:0]  pairA, pairB;

   logic        pairReq0, te0, eg0, busy0;
   logic [15:0] red0;
   logic [7:0]  green0, score0;
   logic [3:0]  level0, lives0;

   logic        pairReq1, te1, eg1, busy1;
   logic [15:0] red1;
   logic [7:0]  green1, score1;
   logic [3:0]  level1, lives1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   memory_game_multi #(.N_LEDS(16), .IDX_W(5), .MAX_PAIRS(8), .START_PAIRS(3),
      .FLASH_CYCLES(4), .GAP_CYCLES(2), .SCORE_W(8), .LIVES(3), .STRICT(0)) dut0 (
      .clk(clk), .rst(rst), .enable(enable), .bIn(bIn), .switchIn(switchIn),
      .gameTimeout(gameTimeout), .pairReq(pairReq0), .pairValid(pairValid),
      .pairA(pairA), .pairB(pairB), .redLight(red0), .greenLight(green0),
      .score(score0), .level(level0), .livesLeft(lives0), .timerEnable(te0),
      .endGame(eg0), .busy(busy0));

   memory_game_multi #(.N_LEDS(16), .IDX_W(4), .MAX_PAIRS(8), .START_PAIRS(3),
      .FLASH_CYCLES(4), .GAP_CYCLES(2), .SCORE_W(8), .LIVES(2), .STRICT(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .bIn(bIn), .switchIn(switchIn),
      .gameTimeout(gameTimeout), .pairReq(pairReq1), .pairValid(pairValid),
      .pairA(pairA[3:0]), .pairB(pairB[3:0]), .redLight(red1), .greenLight(green1),
      .score(score1), .level(level1), .livesLeft(lives1), .timerEnable(te1),
      .endGame(eg1), .busy(busy1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_game();
      bIn = 1'b1;
      @(negedge clk);
      bIn = 1'b0;
   endtask

   task automatic press(input logic [15:0] sw);
      switchIn = sw;
      bIn      = 1'b1;
      @(negedge clk);
      bIn      = 1'b0;
   endtask

   task automatic give(input logic [4:0] a, input logic [4:0] b);
      pairA     = a;
      pairB     = b;
      pairValid = 1'b1;
      for (int i = 0; i < 20 && !pairReq0; i++) @(negedge clk);
      check("give_req", pairReq0, 1);
      @(negedge clk);
      pairValid = 1'b0;
   endtask

   task automatic check_reset0();
      check("rst_red", red0, 0);
      check("rst_green", green0, 0);
      check("rst_score", score0, 0);
      check("rst_level", level0, 3);
      check("rst_lives", lives0, 3);
      check("rst_req", pairReq0, 0);
      check("rst_timer", te0, 0);
      check("rst_end", eg0, 0);
      check("rst_busy", busy0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] seq [16];
      seq = '{16'h0022, 16'h0022, 16'h0022, 16'h0022, 16'h0000, 16'h0000,
              16'h0204, 16'h0204, 16'h0204, 16'h0204, 16'h0000, 16'h0000,
              16'h8001, 16'h8001, 16'h8001, 16'h8001};
      rst = 1'b0; enable = 1'b1; bIn = 1'b0; gameTimeout = 1'b0;
      pairValid = 1'b0; switchIn = '0; pairA = '0; pairB = '0;
      repeat (2) @(negedge clk);
      check_reset0();
      check("rst_lives1", lives1, 2);

      // round 1: load, flash sequence, entries
      rst = 1'b1;
      start_game();
      check("load_busy", busy0, 1);
      give(5'd1, 5'd5);
      give(5'd2, 5'd9);
      give(5'd0, 5'd15);
      check("load_done_req", pairReq0, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("flash_%0d", i), red0, seq[i]);
      end
      @(negedge clk);
      check("enter_red", red0, 0);
      check("enter_timer", te0, 1);
      press(16'h0023);
      check("wrong_green", green0, 0);
      check("wrong_lives", lives0, 3);
      press(16'h0022);
      check("green_1", green0, 8'h01);
      press(16'h0204);
      check("green_3", green0, 8'h03);
      press(16'h8001);
      check("green_7", green0, 8'h07);
      @(negedge clk);
      check("win_score", score0, 3);
      check("win_level", level0, 4);
      check("win_req", pairReq0, 1);
      check("win_green", green0, 0);
      check("win_timer", te0, 1);

      // invalid pairs dropped, then freeze during first flash
      give(5'd3, 5'd3);
      check("same_req", pairReq0, 1);
      give(5'd7, 5'd16);
      check("range_req", pairReq0, 1);
      give(5'd3, 5'd4);
      check("valid_req", pairReq0, 1);
      give(5'd6, 5'd8);
      give(5'd10, 5'd11);
      give(5'd12, 5'd13);
      check("load2_req", pairReq0, 0);
      repeat (2) begin
         @(negedge clk);
         check("pair0_flash", red0, 16'h0018);
      end
      enable = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("freeze_red", red0, 16'h0018);
      end
      enable = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("resume_red", red0, 16'h0018);
      end
      @(negedge clk);
      check("late_gap", red0, 0);
      repeat (2) @(negedge clk);
      check("pair1_flash", red0, 16'h0140);
      repeat (16) @(negedge clk);
      check("enter2_timer", te0, 1);
      check("enter2_score", score0, 3);
      check("enter2_busy", busy0, 1);

      // reset during ENTER
      rst = 1'b0;
      @(negedge clk);
      check_reset0();

      // timeout mid-flash
      rst = 1'b1;
      start_game();
      give(5'd1, 5'd5);
      give(5'd2, 5'd9);
      give(5'd0, 5'd15);
      repeat (2) begin
         @(negedge clk);
         check("to_flash", red0, 16'h0022);
      end
      gameTimeout = 1'b1;
      @(negedge clk);
      gameTimeout = 1'b0;
      check("to_red", red0, 0);
      check("to_end", eg0, 1);
      check("to_timer", te0, 0);
      check("to_busy", busy0, 1);
      @(negedge clk);
      check("to_idle", busy0, 0);
      check("to_end_hold", eg0, 1);
      check("to_level", level0, 3);

      // strict mode: two wrong entries end the game
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("s_lives_rst", lives1, 2);
      start_game();
      give(5'd1, 5'd5);
      give(5'd2, 5'd9);
      give(5'd0, 5'd15);
      for (int i = 0; i < 100 && !te1; i++) @(negedge clk);
      check("s_enter", te1, 1);
      press(16'h0001);
      check("s_lives_1", lives1, 1);
      check("s_end_0", eg1, 0);
      check("s_busy", busy1, 1);
      press(16'h0001);
      check("s_lives_0", lives1, 0);
      check("s_end_1", eg1, 1);
      check("s_timer", te1, 0);
      @(negedge clk);
      check("s_idle", busy1, 0);
      check("s_score", score1, 0);
      check("s_level", level1, 3);
      check("s_green", green1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
